// File: rtl/toggle_edge_tracker.sv
// Per-bit toggle tracker: pulses valid[i] once bit i has both risen and fallen.
// Optional build macro TOGGLE_STICKY_EN: each bit reports only its first toggle.
module toggle_edge_tracker #(
   parameter  int WIDTH = 7,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig,
   input  logic             en,
   input  logic             clear,
   output logic [WIDTH-1:0] valid,
   output logic [CNT_W-1:0] covered_cnt,
   output logic             all_covered,
   output logic             dbg_state
);

   // valid has no ready: each bit is a fire-and-forget one-cycle pulse that the
   // downstream module must take in the cycle it is high.
   typedef enum logic [0:0] {
      INIT  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise_seen;
   logic [WIDTH-1:0] fall_seen;
   logic [WIDTH-1:0] reported;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] f_acc;
   logic [WIDTH-1:0] done;
   logic [WIDTH-1:0] pulse;
   logic [WIDTH-1:0] keep_mask;
   logic [WIDTH-1:0] first_hit;
   logic [CNT_W-1:0] cnt_next;

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   always_comb begin
      rise      = ~prev & sig;
      fall      = prev & ~sig;
      r_acc     = rise_seen | rise;
      f_acc     = fall_seen | fall;
      done      = r_acc & f_acc;
      first_hit = done & ~reported;
`ifdef TOGGLE_STICKY_EN
      // Bits that already reported stay silent and keep no partial history.
      pulse     = first_hit;
      keep_mask = ~done & ~reported;
`else
      pulse     = done;
      keep_mask = ~done;
`endif
      cnt_next  = covered_cnt + popcount(first_hit);
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         state       <= INIT;
         prev        <= '0;
         rise_seen   <= '0;
         fall_seen   <= '0;
         reported    <= '0;
         valid       <= '0;
         covered_cnt <= '0;
         all_covered <= 1'b0;
      end else begin
         valid <= '0;
         if (en) begin
            case (state)
               INIT: begin
                  prev  <= sig;
                  state <= ARMED;
               end
               ARMED: begin
                  valid       <= pulse;
                  rise_seen   <= r_acc & keep_mask;
                  fall_seen   <= f_acc & keep_mask;
                  reported    <= reported | done;
                  covered_cnt <= cnt_next;
                  all_covered <= (cnt_next == CNT_W'(WIDTH));
                  prev        <= sig;
               end
               default: state <= INIT;
            endcase
         end
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_toggle_edge_tracker.sv
// Directed bench for toggle_edge_tracker: driver pushes hand-computed results,
// a monitor pops and compares one entry per clock after each active edge.
module tb_toggle_edge_tracker;

   localparam int WIDTH = 7;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int EW    = WIDTH + CNT_W + 2;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] sig;
   logic             en;
   logic             clear;
   logic [WIDTH-1:0] valid;
   logic [CNT_W-1:0] covered_cnt;
   logic             all_covered;
   logic             dbg_state;

   logic [EW-1:0] exp_q[$];
   int            n_checks;
   int            n_fail;
   int            step_no;

   toggle_edge_tracker #(.WIDTH(WIDTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .sig         (sig),
      .en          (en),
      .clear       (clear),
      .valid       (valid),
      .covered_cnt (covered_cnt),
      .all_covered (all_covered),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   // driver: inputs change on the falling edge, the result after the next
   // rising edge is pushed at the same time
   task automatic drive(input logic r, input logic c, input logic e,
                        input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] ev,
                        input logic [CNT_W-1:0] ec, input logic ea, input logic es);
      @(negedge clock);
      reset = r;
      clear = c;
      en    = e;
      sig   = s;
      exp_q.push_back({ev, ec, ea, es});
   endtask

   // monitor / scoreboard
   initial begin
      logic [EW-1:0] exp_v;
      logic [EW-1:0] act_v;
      n_checks = 0;
      n_fail   = 0;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {valid, covered_cnt, all_covered, dbg_state};
            n_checks++;
            if (act_v !== exp_v) begin
               n_fail++;
               $display("FAIL cycle_%0d: got valid=%h cnt=%0d all=%b state=%b, want valid=%h cnt=%0d all=%b state=%b",
                        n_checks, valid, covered_cnt, all_covered, dbg_state,
                        exp_v[EW-1 -: WIDTH], exp_v[CNT_W+1 -: CNT_W], exp_v[1], exp_v[0]);
            end
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] rep_v;
      logic [WIDTH-1:0] par_v;
`ifdef TOGGLE_STICKY_EN
      rep_v = 7'h00;
      par_v = 7'h7E;
`else
      rep_v = 7'h01;
      par_v = 7'h7F;
`endif
      reset = 1'b1;
      clear = 1'b0;
      en    = 1'b0;
      sig   = '0;
      step_no = 0;

      // reset and INIT capture
      drive(1, 0, 0, 7'h00, 7'h00, 0, 0, 0);
      drive(1, 0, 0, 7'h00, 7'h00, 0, 0, 0);
      drive(0, 0, 1, 7'h00, 7'h00, 0, 0, 1);
      drive(0, 0, 1, 7'h00, 7'h00, 0, 0, 1);
      // single toggle on bit 0
      drive(0, 0, 1, 7'h01, 7'h00, 0, 0, 1);
      drive(0, 0, 1, 7'h00, 7'h01, 1, 0, 1);
      drive(0, 0, 1, 7'h00, 7'h00, 1, 0, 1);
      // repeat toggle on bit 0
      drive(0, 0, 1, 7'h01, 7'h00, 1, 0, 1);
      drive(0, 0, 1, 7'h00, rep_v, 1, 0, 1);
      drive(0, 0, 1, 7'h00, 7'h00, 1, 0, 1);
      // all bits toggle together
      drive(0, 0, 1, 7'h7F, 7'h00, 1, 0, 1);
      drive(0, 0, 1, 7'h00, par_v, 7, 1, 1);
      drive(0, 0, 1, 7'h00, 7'h00, 7, 1, 1);
      // clear, then en gating on bit 2
      drive(0, 1, 1, 7'h00, 7'h00, 0, 0, 0);
      drive(0, 0, 1, 7'h00, 7'h00, 0, 0, 1);
      drive(0, 0, 1, 7'h04, 7'h00, 0, 0, 1);
      drive(0, 0, 0, 7'h00, 7'h00, 0, 0, 1);
      drive(0, 0, 0, 7'h04, 7'h00, 0, 0, 1);
      drive(0, 0, 1, 7'h00, 7'h04, 1, 0, 1);
      drive(0, 0, 1, 7'h00, 7'h00, 1, 0, 1);
      // clear after a lone bit-3 rise discards it
      drive(0, 0, 1, 7'h08, 7'h00, 1, 0, 1);
      drive(0, 1, 1, 7'h00, 7'h00, 0, 0, 0);
      drive(0, 0, 1, 7'h08, 7'h00, 0, 0, 1);
      drive(0, 0, 1, 7'h00, 7'h00, 0, 0, 1);
      drive(0, 0, 1, 7'h08, 7'h08, 1, 0, 1);
      drive(0, 0, 1, 7'h08, 7'h00, 1, 0, 1);
      // reset mid-run, INIT holds while en=0
      drive(1, 0, 1, 7'h00, 7'h00, 0, 0, 0);
      drive(0, 0, 0, 7'h00, 7'h00, 0, 0, 0);
      drive(0, 0, 1, 7'h00, 7'h00, 0, 0, 1);

      @(negedge clock);
      en = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/toggle_edge_tracker.md
Name: toggle_edge_tracker

Overview:
Per-bit toggle detector that sits directly upstream of the GEN_w*_toggle cover-report modules. It watches a WIDTH-bit design signal and records rising and falling transitions per bit. It emits a one-cycle valid pulse for a bit when that bit completes a full toggle (both 0->1 and 1->0 seen). It also tracks how many distinct bits have ever completed a toggle since reset/clear. Its valid output connects bit-for-bit to the valid input of the downstream cover-report module.

Parameters:
WIDTH, 7, number of monitored bits; also the width of sig and valid.
CNT_W, $clog2(WIDTH+1), width of covered_cnt (derived; not overridden).

Ports:
clock  input  1  sole clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
sig  input  WIDTH  monitored design signal, sampled each cycle en=1.
en  input  1  sample enable; when 0, no sampling, no detection, state frozen.
clear  input  1  synchronous soft clear of all tracking state; same effect as reset.
valid  output  WIDTH  registered one-cycle pulse per bit on toggle completion.
covered_cnt  output  CNT_W  number of distinct bits that have reported at least once.
all_covered  output  1  registered; 1 iff covered_cnt == WIDTH.

Behaviour:
- Reset: synchronous, active-high, on clock posedge.
  - All outputs and internal state go to 0; FSM goes to INIT.
  - Internal state: prev, rise_seen, fall_seen, reported mask.
- FSM, two states:
  - INIT: first cycle with en=1 captures prev<=sig. No edge evaluation; valid stays 0. Go to ARMED.
  - ARMED: stays in ARMED until reset or clear.
  - en=0 in either state: hold the state.
- ARMED, en=1, per bit i:
  - rise = ~prev[i] & sig[i]; fall = prev[i] & ~sig[i].
  - r = rise_seen[i] | rise; f = fall_seen[i] | fall.
  - If r & f: valid[i] is 1 in the next cycle; rise_seen[i] and fall_seen[i] clear to 0; reported[i] <= 1.
  - Otherwise: rise_seen[i] <= r; fall_seen[i] <= f.
  - prev <= sig.
- Latency: valid[i] is high exactly one cycle, in the cycle after the sampling edge that completed the toggle. valid = 0 in every cycle not so triggered, including every cycle after an en=0 sample cycle.
- A single sample cannot both rise and fall. A full toggle needs at least two ARMED samples after the first captured sample, so the minimum from the first en=1 cycle is 3 enabled cycles.
- Multiple bits may complete a toggle in the same cycle; each gets its own pulse.
- covered_cnt:
  - Adds popcount of (completing bits & ~reported) in the same update as valid.
  - A bit's first report increments the count; later reports do not.
  - Never exceeds WIDTH, so no wrap is possible.
- all_covered is registered and updates in the same cycle as covered_cnt.
- clear:
  - Same next-state effect as reset; outputs are 0 in the next cycle.
  - clear with en=1 in the same cycle: clear wins, no detection, no sample captured.
  - clear or reset mid-toggle discards the partial rise_seen/fall_seen flags.
- sig is sampled only on clock edges. A glitch between edges is not a toggle.

Optional Feature:
TOGGLE_STICKY_EN
- Defined: once reported[i]=1, bit i never pulses valid again until reset or clear. Its rise_seen/fall_seen stay 0. This gives first-hit-only reporting to cut DPI call volume downstream.
- Undefined: bit i pulses on every completed rise+fall pair, as described in Behaviour. covered_cnt behaves identically in both builds.

Test Plan:
- Reset/INIT: reset=1 for 2 cycles, then en=1 with sig=7'h00 held -> valid=0, covered_cnt=0, all_covered=0 throughout. The first en cycle produces no pulse.
- Single toggle: WIDTH=7; sig 0x00 -> 0x01 -> 0x00 on consecutive en cycles -> valid=7'h01 for exactly one cycle, one cycle after the 0x00 return sample; covered_cnt=1.
- Repeat and sticky: repeat the bit-0 toggle a second time -> without TOGGLE_STICKY_EN, valid=7'h01 pulses again and covered_cnt stays 1. With the macro, no second pulse.
- Parallel and full coverage: sig 0x00 -> 0x7F -> 0x00 -> valid=7'h7F for one cycle; covered_cnt=7; all_covered=1 in the same cycle.
- en gating: sig 0x00 -> 0x04 with en=1, then en=0 while sig goes to 0x00 and back to 0x04, then en=1 with sig=0x00 -> valid=0x04 one cycle after the final sample only. No pulse occurs during the en=0 cycles.
- Clear mid-operation: after a bit-3 rise only, assert clear together with en=1 and sig=0x00 -> no pulse; covered_cnt=0; FSM in INIT. A following fall alone produces no pulse; bit 3 needs a fresh rise and fall.
